// File: rtl/fir_tdm_controller_if.sv
// fir_tdm_controller_if: sample, result, coefficient and status signals of the TDM FIR sequencer
interface fir_tdm_controller_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic signed [DATA_W-1:0]  x;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [DATA_W-1:0]  y;
   logic                      coef_we;
   logic [$clog2(TAPS)-1:0]   coef_addr;
   logic signed [COEF_W-1:0]  coef_data;
   logic                      coef_err;
   logic                      flush;
   logic                      busy;
   modport master (
      output in_valid, x, out_ready, coef_we, coef_addr, coef_data, flush,
      input  in_ready, out_valid, y, coef_err, busy
   );
   modport slave (
      input  in_valid, x, out_ready, coef_we, coef_addr, coef_data, flush,
      output in_ready, out_valid, y, coef_err, busy
   );
endinterface

// File: rtl/fir_tdm_controller.sv
// fir_tdm_controller: time-multiplexed FIR, one MAC per tap per cycle, saturated scaled output
module fir_tdm_controller #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   parameter int ACC_W  = 40,
   parameter int SHIFT  = 15
) (
   input logic clk,
   input logic reset,
   fir_tdm_controller_if.slave bus
);
   localparam int AW = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;
   localparam logic [AW-1:0] KMAX = AW'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state, state_nx;
   logic signed [DATA_W-1:0] smp [TAPS];
   logic signed [COEF_W-1:0] coef [TAPS];
   logic [AW-1:0] wr_ptr, base, k, rd;
   logic signed [PW-1:0] prod;
   logic signed [ACC_W-1:0] acc, acc_nx, shifted;
   logic signed [DATA_W-1:0] y_q, y_sat;
   logic coef_err_q;
   // next state: flush wins over a sample in IDLE, MAC runs exactly TAPS cycles, OUT waits for the handshake
   always_comb begin
      state_nx = state;
      if (state == IDLE) state_nx = bus.flush ? IDLE : bus.in_valid ? MAC : IDLE;
      else if (state == MAC) state_nx = (k == KMAX) ? OUT : MAC;
      else state_nx = bus.out_ready ? IDLE : OUT;
   end
   // one tap product, running sum, scaling and clamp of the sum that includes the current tap
   always_comb begin
      rd = base - k;
      prod = PW'(coef[k]) * PW'(smp[rd]);
      acc_nx = acc + ACC_W'(prod);
      shifted = acc_nx >>> SHIFT;
      y_sat = (shifted > YMAX) ? YMAX[DATA_W-1:0] : (shifted < YMIN) ? YMIN[DATA_W-1:0] : shifted[DATA_W-1:0];
   end
   // state, history buffer, coefficient file and accumulator; reset aborts any sample in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         wr_ptr <= '0;
         base <= '0;
         k <= '0;
         acc <= '0;
         y_q <= '0;
         coef_err_q <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            smp[i] <= '0;
            coef[i] <= '0;
         end
      end else begin
         state <= state_nx;
         coef_err_q <= bus.coef_we && state != IDLE;
         if (state == IDLE && bus.coef_we) coef[bus.coef_addr] <= bus.coef_data;
         if (state == IDLE && bus.flush) begin
            for (int i = 0; i < TAPS; i++) smp[i] <= '0;
            wr_ptr <= '0;
         end else if (state == IDLE && bus.in_valid) begin
            smp[wr_ptr] <= bus.x;
            base <= wr_ptr;
            wr_ptr <= wr_ptr + AW'(1);
            acc <= '0;
            k <= '0;
         end
         if (state == MAC) begin
            acc <= acc_nx;
            k <= k + AW'(1);
            if (k == KMAX) y_q <= y_sat;
         end
      end
   end
   assign bus.in_ready = state == IDLE;
   assign bus.busy = state != IDLE;
   assign bus.out_valid = state == OUT;
   assign bus.y = y_q;
   assign bus.coef_err = coef_err_q;
endmodule

// File: doc/fir_tdm_controller.md
Name: fir_tdm_controller

Overview:
- Time-multiplexed FIR sequencer: accepts one 16-bit signed sample per handshake and stores it in a circular sample buffer.
- Sequences a single multiply-accumulate unit over all taps, one tap per cycle, then presents a saturated, scaled result with valid/ready.
- Owns the coefficient register file, which the system configures through a simple write port.
- Sits between the sample source and downstream DSP stages, replacing the fully parallel fir_filter wherever area matters more than throughput.

Parameters:
- DATA_W, 16: sample and output width, signed.
- COEF_W, 16: coefficient width, signed.
- TAPS, 8: number of taps; power of two, at least 2.
- ACC_W, 40: accumulator width; must be at least DATA_W+COEF_W+log2(TAPS).
- SHIFT, 15: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: sample x is valid.
- in_ready, output, 1: controller can accept a sample.
- x, input, DATA_W: signed input sample.
- out_valid, output, 1: y is valid.
- out_ready, input, 1: downstream accepts y.
- y, output, DATA_W: signed filtered output.
- coef_we, input, 1: coefficient write strobe.
- coef_addr, input, log2(TAPS): coefficient index k.
- coef_data, input, COEF_W: signed coefficient value.
- coef_err, output, 1: one-cycle pulse when a coefficient write is rejected.
- flush, input, 1: clears sample history.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All sample buffer entries, all coefficients, wr_ptr, tap counter and accumulator are cleared to 0.
  - Outputs: y=0, out_valid=0, coef_err=0, busy=0, in_ready=1.
  - Reset asserted mid-MAC or mid-OUT aborts the operation; no output is produced for the aborted sample.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: buf[wr_ptr] <= x, base <= wr_ptr, wr_ptr <= (wr_ptr+1) mod TAPS, acc <= 0, k <= 0, go to MAC.
- MAC (exactly TAPS cycles):
  - in_ready=0.
  - Each edge: acc <= acc + coef[k]*buf[(base-k) mod TAPS], full-precision signed product sign-extended to ACC_W; k <= k+1.
  - On the edge where k=TAPS-1: y <= sat(acc_final >>> SHIFT) and go to OUT.
  - sat() clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - The computed value is y[n] = sum over k of coef[k]*x[n-k]; history before reset or flush counts as 0.
- OUT:
  - out_valid=1 and y is held stable until out_ready=1 at an edge.
  - On that edge: out_valid <= 0, go to IDLE.
  - y keeps its last value after out_valid drops.
- Latency: accept edge is E0. out_valid is first high in the cycle after edge E0+TAPS, i.e. after TAPS+1 edges.
- Throughput: the next accept is possible no earlier than the edge after the out_ready handshake. Minimum period is TAPS+2 cycles per sample.
- Coefficient writes:
  - Accepted only in IDLE: coef[coef_addr] <= coef_data.
  - In MAC or OUT the write is ignored and coef_err pulses high for one cycle.
  - coef_we and in_valid asserted in the same IDLE cycle: both take effect. The sample's computation uses the new coefficient.
- flush:
  - Honoured only in IDLE: all buf entries <= 0 and wr_ptr <= 0 in one edge.
  - flush has priority over in_valid in the same cycle; that sample is not accepted and in_ready stays 1.
  - flush in other states is ignored.
- wr_ptr wraps from TAPS-1 to 0. The read index (base-k) wraps modulo TAPS.
- busy=1 in MAC and OUT.

Test Plan:
- Impulse response: load coef = {100,200,300,400,500,600,700,800}, SHIFT=0 build, feed x=1 then seven zeros. Required y sequence is 100,200,...,800, each out_valid appearing 9 cycles after its accept edge.
- Averaging: coef[0]=coef[1]=16384, all others 0, SHIFT=15. Feed x=100, 200, 150. Required y = 50, 150, 175.
- Saturation: all coef=32767. Eight x=32767 in a row must end at y=32767; then eight x=-32768 must end at y=-32768. No wrap-around is allowed.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid rises. y must stay constant, in_ready=0 throughout, and the next sample is accepted only after the handshake.
- Config protection: coef_we during MAC gives a coef_err one-cycle pulse and the coefficient is unchanged (verified via the next impulse). A flush in IDLE followed by x=1 must reproduce the pure impulse response.
- Reset mid-MAC: drop reset at the 4th MAC cycle. All outputs go to reset values immediately, out_valid never rises for that sample, and after release the first sample behaves as in the impulse test with coefficients at 0, giving y=0.
